// File: rtl/clk_divider_multi.sv
// -----------------------------------------------------------------------------
// clk_divider_multi
//
// Purpose:
//   Multi-channel clock divider. Each channel produces a divided clock-enable
//   waveform (clk_o) and a one-cycle tick at the start of every period
//   (tick_o) from the single system clock. Channels have individual enables,
//   reload their divide ratio only at period boundaries (so a ratio change
//   never produces a runt or stretched pulse), and can all be restarted at
//   phase 0 by the global sync strobe.
//
// Parameters:
//   WIDTH     bit width of each divide ratio and phase counter
//   CHANNELS  number of independent divider channels
//
// Ports:
//   clk_i     in   1               system clock, rising edge
//   rst_n_i   in   1               synchronous active-low reset
//   en_i      in   CHANNELS        per-channel enable
//   div_i     in   CHANNELS*WIDTH  per-channel divide ratio D, [n*WIDTH +: WIDTH]
//   sync_i    in   1               restart all enabled channels at phase 0
//   clk_o     out  CHANNELS        divided clock (registered)
//   tick_o    out  CHANNELS        one-cycle pulse at phase 0
//   active_o  out  CHANNELS        channel running with D >= 2
// -----------------------------------------------------------------------------
module clk_divider_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS*WIDTH-1:0] div_i,
  input  logic                      sync_i,
  output logic [CHANNELS-1:0]       clk_o,
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       active_o
);

  // ST_OFF   : just left reset, no ratio captured yet.
  // ST_ARMED : ratio captured (disabled, or first edge after reset); the next
  //            enabled edge starts the channel at phase 0.
  // ST_RUN   : producing the waveform.
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [WIDTH-1:0] cnt_reg, cnt_next;
      logic [WIDTH-1:0] div_reg, div_next;
      logic [WIDTH-1:0] div_in;
      logic [WIDTH:0]   cnt_inc;
      logic [WIDTH:0]   half_next;
      logic             wrap;
      logic             run_next;
      logic             clk_reg, clk_next;
      logic             tick_reg, tick_next;
      logic             act_reg, act_next;

      assign div_in = div_i[gi*WIDTH +: WIDTH];

      // Extra bit keeps cnt+1 == D exact even for D = 2^WIDTH-1; for D = 1
      // this is true at cnt = 0, so a D=1 channel wraps (and ticks) every cycle.
      assign cnt_inc = {1'b0, cnt_reg} + (WIDTH+1)'(1);
      assign wrap    = (cnt_inc == {1'b0, div_reg});

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        div_next   = div_reg;

        if (!en_i[gi]) begin
          // Disabled: hold phase 0 and keep tracking the requested ratio.
          state_next = ST_ARMED;
          cnt_next   = '0;
          div_next   = div_in;
        end else if (sync_i) begin
          // Sync outranks the natural wrap, so a coincident wrap yields a
          // single phase-0 cycle.
          state_next = ST_RUN;
          cnt_next   = '0;
          div_next   = div_in;
        end else begin
          case (state_reg)
            ST_OFF: begin
              state_next = ST_ARMED;
              cnt_next   = '0;
              div_next   = div_in;
            end
            ST_ARMED: begin
              // Start with the ratio captured on the previous cycle.
              state_next = ST_RUN;
              cnt_next   = '0;
            end
            default: begin
              if (div_reg == '0) begin
                // Idle ratio: keep re-sampling until a usable value arrives.
                cnt_next = '0;
                div_next = div_in;
              end else if (wrap) begin
                cnt_next = '0;
                div_next = div_in;
              end else begin
                cnt_next = cnt_inc[WIDTH-1:0];
              end
            end
          endcase
        end
      end

      // Outputs are decoded from the next state so the registered outputs
      // line up with the registered phase after the same edge.
      assign run_next  = (state_next == ST_RUN);
      assign half_next = ({1'b0, div_next} + (WIDTH+1)'(1)) >> 1;

      always_comb begin
        clk_next  = 1'b0;
        tick_next = 1'b0;
        act_next  = 1'b0;
        if (run_next && (div_next != '0)) begin
          clk_next  = ({1'b0, cnt_next} < half_next);
          tick_next = (cnt_next == '0);
          act_next  = (div_next > WIDTH'(1));
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          state_reg <= ST_OFF;
          cnt_reg   <= '0;
          div_reg   <= '0;
          clk_reg   <= 1'b0;
          tick_reg  <= 1'b0;
          act_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          div_reg   <= div_next;
          clk_reg   <= clk_next;
          tick_reg  <= tick_next;
          act_reg   <= act_next;
        end
      end

      assign clk_o[gi]    = clk_reg;
      assign tick_o[gi]   = tick_reg;
      assign active_o[gi] = act_reg;
    end
  endgenerate

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Parametrised, multi-channel successor to the single-channel 16-bit clock divider.
- Generates CHANNELS independent divided clock-enable waveforms (clk_o) and one-cycle period ticks (tick_o) from one system clock.
- Supports per-channel enable, glitch-free divider reload at period boundaries, and a global phase-align (sync) strobe.
- Feeds the LED PWM channels and any other logic that needs slow, phase-aligned timebases.

Parameters:
- WIDTH, 16, bit width of each divider value and phase counter.
- CHANNELS, 4, number of independent divider channels.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- en_i  in  CHANNELS  per-channel enable.
- div_i  in  CHANNELS*WIDTH  per-channel divide ratio D; channel n uses bits [n*WIDTH +: WIDTH].
- sync_i  in  1  one-cycle strobe; restarts all enabled channels at phase 0.
- clk_o  out  CHANNELS  divided clock per channel; registered and glitch-free.
- tick_o  out  CHANNELS  one-cycle pulse at the start of each period.
- active_o  out  CHANNELS  high while the channel is running with D>=2.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- While rst_n_i=0 at a rising edge, every channel loads cnt=0 and div_q=0. All of clk_o, tick_o and active_o are 0 after that edge.
- Per-channel state: phase counter cnt (WIDTH bits) and the active divide value div_q (WIDTH bits). No state is shared between channels except sync_i.
- Output registers: all outputs are registered and reflect the state after the same edge. The "phase" below means the registered cnt.
- Waveform for D=div_q>=2:
  - Period is D cycles. cnt runs 0..D-1, then wraps to 0.
  - clk_o=1 for phases 0..ceil(D/2)-1 and 0 otherwise. Odd D gives the extra cycle high.
  - tick_o=1 exactly when phase=0.
  - active_o=1.
- Disabled (en_i[n]=0): at each edge cnt<=0 and div_q<=div_i[n]. clk_o, tick_o and active_o are 0 after that edge.
- Start: at the first edge where en_i[n]=1 after being 0, the channel enters phase 0 using div_q captured on the previous cycle. clk_o and tick_o are 1 after that edge, so first-edge latency is 1 cycle.
- Reload:
  - div_i changes while running are ignored mid-period.
  - div_i is sampled into div_q only on the edge where cnt wraps to 0. The new period uses the new D, so no runt or stretched pulse occurs.
- Degenerate D:
  - D=0: channel idle. clk_o=0, tick_o=0, active_o=0, cnt held 0. div_i is re-sampled every cycle, so a non-zero value starts phase 0 on the next edge.
  - D=1: clk_o=1 constantly, tick_o=1 every cycle, active_o=0.
- sync_i=1 at an edge: every enabled channel sets cnt<=0 and div_q<=div_i[n], giving clk_o=1 and tick_o=1 after that edge. Disabled channels are unaffected.
- Precedence, highest first: reset > en_i=0 > sync_i > natural wrap/reload > count.
- sync_i asserted on the same edge as a natural wrap gives a single phase-0 cycle, never two ticks.
- Arithmetic:
  - Half-point is (D+1)>>1, computed in WIDTH+1 bits.
  - The wrap compare is cnt==D-1 for D>=2, with no WIDTH overflow at D=2^WIDTH-1.
- Reset mid-operation: outputs are 0 after the reset edge. After release the channel restarts from phase 0 via the start rule.

Test Plan:
1. Reset, then CHANNELS=4; en_i=4'b0001, div_i[0]=10 -> clk_o[0] is 5 high / 5 low; tick_o[0] pulses every 10 cycles and coincides with the clk_o[0] rise; first tick 1 cycle after en_i rises.
2. div_i[0]=7 -> clk_o[0] is 4 high / 3 low. Switch to div_i[0]=4 at phase 2 -> current 7-cycle period completes, then 2 high / 2 low; no short pulse.
3. div_i=0 and div_i=1 on channels 1 and 2, enabled -> ch1: clk_o=0, tick_o=0, active_o=0. ch2: clk_o=1, tick_o=1 every cycle, active_o=0.
4. Channels 0..3 with D=3,5,8,10, free-running, then pulse sync_i -> on the next cycle all four show clk_o=1 and tick_o=1 at phase 0, and periods run from there.
5. sync_i asserted on the exact wrap cycle of a D=6 channel -> a single tick, and the next tick follows 6 cycles later.
6. Deassert rst_n_i mid-period with D=10 -> after the reset edge all outputs are 0. Release rst_n_i with en_i held high -> phase 0 is reached 1 cycle after the first non-reset edge captures D.
